seq_multdiv: RTL

SEQ_MULTDIV -- requirements
Module: seq_multdiv

---
 rtl/seq_multdiv_if.sv | 20 ++
 rtl/seq_multdiv.sv | 108 ++++++++++
 2 files changed

// File: rtl/seq_multdiv_if.sv
// rtl/seq_multdiv_if.sv - operand, control and result bundle for seq_multdiv
interface seq_multdiv_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/seq_multdiv.sv
// rtl/seq_multdiv.sv - 32-bit signed sequential multiplier / divider, one radix-2 step per cycle
module seq_multdiv (
  input  logic         clock,
  input  logic         reset,
  seq_multdiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_a, r_b, r_hi, r_lo, r_result;
  logic [5:0]  r_cnt;
  logic        r_exc, r_rdy;

  logic        w_start, w_busy, w_last, w_neg, w_fin_exc;
  logic [31:0] w_mag_in_a, w_mag_b, w_quot, w_fin_result;
  logic [32:0] w_mul_sum, w_rem_sh, w_diff;
  logic [63:0] w_prod;

  assign w_start    = bus.ctrl_MULT | bus.ctrl_DIV;
  assign w_busy     = (r_state == MUL) || (r_state == DIV);
  assign w_last     = w_busy && (r_cnt == 6'd32);
  assign w_neg      = r_a[31] ^ r_b[31];
  assign w_mag_in_a = bus.data_operandA[31] ? -bus.data_operandA : bus.data_operandA;
  assign w_mag_b    = r_b[31] ? -r_b : r_b;

  // {r_hi, r_lo}: shift-add accumulator for MUL; remainder/quotient pair for DIV
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, w_mag_b} : 33'd0);
  assign w_rem_sh  = {r_hi, r_lo[31]};
  assign w_diff    = w_rem_sh - {1'b0, w_mag_b};
  assign w_prod    = w_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quot    = w_neg ? -r_lo : r_lo;

  always_comb begin
    w_fin_result = w_prod[31:0];
    w_fin_exc    = (w_prod[63:32] != {32{w_prod[31]}});
    if (r_state == DIV) begin
      if (r_b == 32'd0) begin
        w_fin_result = 32'd0;
        w_fin_exc    = 1'b1;
      end else if (r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) begin
        w_fin_result = 32'h8000_0000;
        w_fin_exc    = 1'b1;
      end else begin
        w_fin_result = w_quot;
        w_fin_exc    = 1'b0;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = bus.ctrl_MULT ? MUL : DIV;
    end else begin
      case (r_state)
        IDLE:    w_state_next = IDLE;
        MUL,
        DIV:     w_state_next = w_last ? DONE : r_state;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= (w_state_next == DONE);
      if (w_start) begin
        r_a   <= bus.data_operandA;
        r_b   <= bus.data_operandB;
        r_hi  <= '0;
        r_lo  <= w_mag_in_a;
        r_cnt <= '0;
      end else if (w_busy && !w_last) begin
        r_cnt <= r_cnt + 6'd1;
        if (r_state == MUL) begin
          r_hi <= w_mul_sum[32:1];
          r_lo <= {w_mul_sum[0], r_lo[31:1]};
        end else begin
          r_hi <= w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0];
          r_lo <= {r_lo[30:0], ~w_diff[32]};
        end
      end
      if (w_state_next == DONE) begin
        r_result <= w_fin_result;
        r_exc    <= w_fin_exc;
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = r_rdy;
endmodule
